power_load_sequencer: RTL and testbench

Controller that sequences enable of a bank of counter-array load blocks for FPGA power characterisation. It ramps the number of enabled banks up to a programmed target at a fixed dwell per step, holds, then ramps back down, so supply transients stay bounded. An optional 1/16-granularity duty-cycle gate modulates switching activity. One instance drives the per-bank clock-enable/reset lines of the power-test load array.

---
 rtl/power_load_sequencer.sv | 175 +++++++++++++++++
 tb/tb_power_load_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_load_sequencer.sv
// Ramps the number of enabled load banks up to a target at a fixed dwell per step,
// holds, then ramps back down. A 1/16 duty gate modulates the enables.
module power_load_sequencer #(
  parameter int NUM_BANKS = 8,
  parameter int DWELL_W   = 24,
  parameter int CNT_W     = $clog2(NUM_BANKS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [CNT_W-1:0]     target_banks,
  input  logic [DWELL_W-1:0]   dwell_cycles,
  input  logic [DWELL_W-1:0]   hold_cycles,
  input  logic [3:0]           duty,
  output logic [NUM_BANKS-1:0] bank_en,
  output logic [CNT_W-1:0]     active_banks,
  output logic [1:0]           state,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_BANKS = CNT_W'(NUM_BANKS);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       active_q, active_d;
  logic [CNT_W-1:0]       target_cfg_q, target_cfg_d;
  logic [DWELL_W-1:0]     dwell_cfg_q, dwell_cfg_d;
  logic [DWELL_W-1:0]     hold_cfg_q, hold_cfg_d;
  logic [3:0]             duty_cfg_q, duty_cfg_d;
  logic [DWELL_W-1:0]     dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [3:0]             phase_q;
  logic [NUM_BANKS-1:0]   bank_en_q, bank_en_d;
  logic                   done_q, done_d;

  logic [CNT_W-1:0]       eff_target;
  logic [DWELL_W-1:0]     eff_dwell;
  logic [DWELL_W-1:0]     dwell_reload;
  logic                   step;

  assign eff_target   = (target_banks > MAX_BANKS) ? MAX_BANKS : target_banks;
  assign eff_dwell    = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
  assign dwell_reload = dwell_cfg_q - DWELL_W'(1);
  assign step         = (dwell_cnt_q == '0);

  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    target_cfg_d = target_cfg_q;
    dwell_cfg_d  = dwell_cfg_q;
    hold_cfg_d   = hold_cfg_q;
    duty_cfg_d   = duty_cfg_q;
    dwell_cnt_d  = dwell_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (eff_target == '0) begin
            done_d = 1'b1;
          end else begin
            target_cfg_d = eff_target;
            dwell_cfg_d  = eff_dwell;
            hold_cfg_d   = hold_cycles;
            duty_cfg_d   = duty;
            dwell_cnt_d  = eff_dwell - DWELL_W'(1);
            state_d      = RAMP_UP;
          end
        end
      end

      RAMP_UP: begin
        if (step) begin
          active_d    = active_q + CNT_W'(1);
          dwell_cnt_d = dwell_reload;
        end else begin
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
        end
        // stop outranks the final step; the step itself still lands
        if (stop) begin
          if (active_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d     = RAMP_DOWN;
            dwell_cnt_d = dwell_reload;
          end
        end else if (step && (active_d == target_cfg_q)) begin
          state_d    = HOLD;
          hold_cnt_d = hold_cfg_q - DWELL_W'(1);
        end
      end

      HOLD: begin
        if (stop) begin
          state_d     = RAMP_DOWN;
          dwell_cnt_d = dwell_reload;
        end else if (hold_cfg_q != '0) begin
          if (hold_cnt_q == '0) begin
            state_d     = RAMP_DOWN;
            dwell_cnt_d = dwell_reload;
          end else begin
            hold_cnt_d = hold_cnt_q - DWELL_W'(1);
          end
        end
      end

      RAMP_DOWN: begin
        if (step) begin
          active_d    = active_q - CNT_W'(1);
          dwell_cnt_d = dwell_reload;
          if (active_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bank_en_d = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      bank_en_d[i] = (CNT_W'(i) < active_q) && (phase_q <= duty_cfg_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      active_q     <= '0;
      target_cfg_q <= '0;
      dwell_cfg_q  <= '0;
      hold_cfg_q   <= '0;
      duty_cfg_q   <= '0;
      dwell_cnt_q  <= '0;
      hold_cnt_q   <= '0;
      phase_q      <= '0;
      bank_en_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      target_cfg_q <= target_cfg_d;
      dwell_cfg_q  <= dwell_cfg_d;
      hold_cfg_q   <= hold_cfg_d;
      duty_cfg_q   <= duty_cfg_d;
      dwell_cnt_q  <= dwell_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      phase_q      <= phase_q + 4'd1;
      bank_en_q    <= bank_en_d;
      done_q       <= done_d;
    end
  end

  assign bank_en      = bank_en_q;
  assign active_banks = active_q;
  assign state        = state_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_power_load_sequencer.sv
// Directed bench for power_load_sequencer: table-driven basic ramp plus
// hand-written duty, abort, clamp and reset sequences.
module tb_power_load_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [3:0]  target_banks;
  logic [23:0] dwell_cycles;
  logic [23:0] hold_cycles;
  logic [3:0]  duty;
  logic [7:0]  bank_en;
  logic [3:0]  active_banks;
  logic [1:0]  state;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [3:0] tb_phase;

  typedef struct {
    logic        start;
    logic        stop;
    logic [3:0]  target;
    logic [23:0] dwell;
    logic [23:0] hold;
    logic [3:0]  duty;
    logic [1:0]  exp_state;
    logic [3:0]  exp_active;
    logic [7:0]  exp_en;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs [18];

  power_load_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .target_banks (target_banks),
    .dwell_cycles (dwell_cycles),
    .hold_cycles  (hold_cycles),
    .duty         (duty),
    .bank_en      (bank_en),
    .active_banks (active_banks),
    .state        (state),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // reference phase: cleared by reset, free-running otherwise
  always @(posedge clk) begin
    if (rst) tb_phase <= 4'd0;
    else     tb_phase <= tb_phase + 4'd1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(logic s, logic sp, logic [3:0] tgt, logic [23:0] dw,
                                 logic [23:0] hd, logic [3:0] dt, logic [1:0] st,
                                 logic [3:0] act, logic [7:0] en, logic bsy, logic dn);
    vec_t v;
    v.start = s; v.stop = sp; v.target = tgt; v.dwell = dw; v.hold = hd; v.duty = dt;
    v.exp_state = st; v.exp_active = act; v.exp_en = en; v.exp_busy = bsy; v.exp_done = dn;
    return v;
  endfunction

  task automatic tick();
    start = 1'b0;
    stop  = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic s, input logic sp, input logic [3:0] tgt,
                               input logic [23:0] dw, input logic [23:0] hd,
                               input logic [3:0] dt);
    start        = s;
    stop         = sp;
    target_banks = tgt;
    dwell_cycles = dw;
    hold_cycles  = hd;
    duty         = dt;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string name, input logic [1:0] st, input logic [3:0] act,
                          input logic [7:0] en, input logic bsy, input logic dn);
    checkOutput({name, ".state"},  32'(state),        32'(st));
    checkOutput({name, ".active"}, 32'(active_banks), 32'(act));
    checkOutput({name, ".bank_en"}, 32'(bank_en),     32'(en));
    checkOutput({name, ".busy"},   32'(busy),         32'(bsy));
    checkOutput({name, ".done"},   32'(done),         32'(dn));
  endtask

  initial begin
    int got;
    int done_cnt;
    int on_cnt;
    logic [3:0] prev_phase;
    logic [3:0] exp_act;
    logic [1:0] exp_st;

    // basic ramp: target 3, dwell 2, hold 4, duty 15; row 3 is an ignored start, row 11 an ignored stop
    vecs[0]  = mkVec(1, 0, 3, 2, 4, 15, 2'd1, 0, 8'h00, 1, 0);
    vecs[1]  = mkVec(0, 0, 3, 2, 4, 15, 2'd1, 0, 8'h00, 1, 0);
    vecs[2]  = mkVec(0, 0, 3, 2, 4, 15, 2'd1, 1, 8'h00, 1, 0);
    vecs[3]  = mkVec(1, 0, 7, 9, 1,  0, 2'd1, 1, 8'h01, 1, 0);
    vecs[4]  = mkVec(0, 0, 3, 2, 4, 15, 2'd1, 2, 8'h01, 1, 0);
    vecs[5]  = mkVec(0, 0, 3, 2, 4, 15, 2'd1, 2, 8'h03, 1, 0);
    vecs[6]  = mkVec(0, 0, 3, 2, 4, 15, 2'd2, 3, 8'h03, 1, 0);
    vecs[7]  = mkVec(0, 0, 3, 2, 4, 15, 2'd2, 3, 8'h07, 1, 0);
    vecs[8]  = mkVec(0, 0, 3, 2, 4, 15, 2'd2, 3, 8'h07, 1, 0);
    vecs[9]  = mkVec(0, 0, 3, 2, 4, 15, 2'd2, 3, 8'h07, 1, 0);
    vecs[10] = mkVec(0, 0, 3, 2, 4, 15, 2'd3, 3, 8'h07, 1, 0);
    vecs[11] = mkVec(0, 1, 3, 2, 4, 15, 2'd3, 3, 8'h07, 1, 0);
    vecs[12] = mkVec(0, 0, 3, 2, 4, 15, 2'd3, 2, 8'h07, 1, 0);
    vecs[13] = mkVec(0, 0, 3, 2, 4, 15, 2'd3, 2, 8'h03, 1, 0);
    vecs[14] = mkVec(0, 0, 3, 2, 4, 15, 2'd3, 1, 8'h03, 1, 0);
    vecs[15] = mkVec(0, 0, 3, 2, 4, 15, 2'd3, 1, 8'h01, 1, 0);
    vecs[16] = mkVec(0, 0, 3, 2, 4, 15, 2'd0, 0, 8'h01, 0, 1);
    vecs[17] = mkVec(0, 0, 3, 2, 4, 15, 2'd0, 0, 8'h00, 0, 0);

    rst = 1'b1; start = 1'b1; stop = 1'b0;
    target_banks = 4'd3; dwell_cycles = 24'd1; hold_cycles = 24'd1; duty = 4'd15;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkAll($sformatf("reset%0d", i), 2'd0, 4'd0, 8'h00, 1'b0, 1'b0);
    end
    rst = 1'b0;
    start = 1'b0;
    tick();
    checkAll("post_reset", 2'd0, 4'd0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].target, vecs[i].dwell,
                    vecs[i].hold, vecs[i].duty);
      checkAll($sformatf("basic%0d", i), vecs[i].exp_state, vecs[i].exp_active,
               vecs[i].exp_en, vecs[i].exp_busy, vecs[i].exp_done);
    end

    $display("[TB] duty gate sequence");
    applyStimulus(1, 0, 4'd8, 24'd1, 24'd0, 4'd7);
    for (int k = 1; k <= 8; k++) tick();
    checkOutput("duty_hold_state", 32'(state), 32'd2);
    checkOutput("duty_hold_active", 32'(active_banks), 32'd8);
    on_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      prev_phase = tb_phase;
      tick();
      checkOutput($sformatf("duty_en%0d", k), 32'(bank_en),
                  (prev_phase <= 4'd7) ? 32'hFF : 32'h00);
      if (bank_en == 8'hFF) on_cnt++;
    end
    checkOutput("duty_on_count", 32'(on_cnt), 32'd16);
    checkOutput("duty_still_hold", 32'(state), 32'd2);
    applyStimulus(0, 1, 4'd8, 24'd1, 24'd0, 4'd7);
    checkOutput("duty_stop_state", 32'(state), 32'd3);
    checkOutput("duty_stop_active", 32'(active_banks), 32'd8);
    got = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin
        got = k;
        break;
      end
    end
    checkOutput("duty_down_len", 32'(got), 32'd8);
    checkOutput("duty_end_state", 32'(state), 32'd0);
    checkOutput("duty_end_active", 32'(active_banks), 32'd0);
    tick();
    checkOutput("duty_done_pulse", 32'(done), 32'd0);

    $display("[TB] abort sequence");
    applyStimulus(1, 0, 4'd6, 24'd4, 24'd0, 4'd15);
    tick();
    applyStimulus(1, 0, 4'd2, 24'd1, 24'd0, 4'd15);
    checkOutput("abort_ignored_start", 32'(state), 32'd1);
    tick();
    tick();
    checkOutput("abort_lvl1", 32'(active_banks), 32'd1);
    for (int k = 5; k <= 8; k++) tick();
    checkOutput("abort_lvl2", 32'(active_banks), 32'd2);
    checkOutput("abort_lvl2_state", 32'(state), 32'd1);
    applyStimulus(0, 1, 4'd6, 24'd4, 24'd0, 4'd15);
    checkOutput("abort_state", 32'(state), 32'd3);
    checkOutput("abort_active", 32'(active_banks), 32'd2);
    done_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (done) done_cnt++;
      if (k <= 8) begin
        exp_act = (k < 4) ? 4'd2 : ((k < 8) ? 4'd1 : 4'd0);
        exp_st  = (k < 8) ? 2'd3 : 2'd0;
        checkOutput($sformatf("abort_down%0d.active", k), 32'(active_banks), 32'(exp_act));
        checkOutput($sformatf("abort_down%0d.state", k), 32'(state), 32'(exp_st));
        checkOutput($sformatf("abort_down%0d.done", k), 32'(done), (k == 8) ? 32'd1 : 32'd0);
      end
    end
    checkOutput("abort_done_count", 32'(done_cnt), 32'd1);

    $display("[TB] stop before first step");
    applyStimulus(1, 0, 4'd3, 24'd5, 24'd0, 4'd15);
    applyStimulus(0, 1, 4'd3, 24'd5, 24'd0, 4'd15);
    checkAll("early_stop", 2'd0, 4'd0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("early_stop_done_clr", 32'(done), 32'd0);

    $display("[TB] stop on final step");
    applyStimulus(1, 0, 4'd2, 24'd1, 24'd0, 4'd15);
    tick();
    applyStimulus(0, 1, 4'd2, 24'd1, 24'd0, 4'd15);
    checkOutput("final_stop_state", 32'(state), 32'd3);
    checkOutput("final_stop_active", 32'(active_banks), 32'd2);
    tick();
    checkOutput("final_stop_lvl1", 32'(active_banks), 32'd1);
    tick();
    checkOutput("final_stop_end", 32'(state), 32'd0);
    checkOutput("final_stop_done", 32'(done), 32'd1);

    $display("[TB] clamp sequence");
    applyStimulus(1, 0, 4'd12, 24'd0, 24'd1, 4'd15);
    for (int k = 1; k <= 8; k++) begin
      tick();
      checkOutput($sformatf("clamp_up%0d", k), 32'(active_banks), 32'(k));
    end
    checkOutput("clamp_hold", 32'(state), 32'd2);
    tick();
    checkOutput("clamp_down_state", 32'(state), 32'd3);
    checkOutput("clamp_down_active", 32'(active_banks), 32'd8);
    for (int k = 1; k <= 8; k++) tick();
    checkAll("clamp_end", 2'd0, 4'd0, 8'h01, 1'b0, 1'b1);

    $display("[TB] zero target");
    tick();
    applyStimulus(1, 0, 4'd0, 24'd3, 24'd0, 4'd15);
    checkAll("zero_tgt", 2'd0, 4'd0, 8'h00, 1'b0, 1'b1);
    tick();
    checkAll("zero_tgt_after", 2'd0, 4'd0, 8'h00, 1'b0, 1'b0);

    $display("[TB] reset mid-hold");
    applyStimulus(1, 0, 4'd5, 24'd1, 24'd0, 4'd15);
    for (int k = 1; k <= 6; k++) tick();
    checkAll("rst_hold_pre", 2'd2, 4'd5, 8'h1F, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    checkAll("rst_hold", 2'd0, 4'd0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    checkAll("rst_hold_after", 2'd0, 4'd0, 8'h00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
